// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a run-time loadable pattern, selectable overlap mode,
// a same-cycle match flag, a registered match flag and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned                PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0]       PAT_RESET = PAT_WIDTH'(4'b1101),
  parameter int unsigned                CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 data_in,
  input  logic                 data_valid,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic                 pattern_load,
  input  logic                 overlap,
  input  logic                 count_clear,
  output logic                 match,
  output logic                 match_q,
  output logic [CNT_WIDTH-1:0] match_count
);

  localparam int unsigned HIST_W = PAT_WIDTH - 1;
  localparam int unsigned FILL_W = $clog2(PAT_WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_W);

  logic [PAT_WIDTH-1:0] pat_r, pat_n;
  logic [HIST_W-1:0]    hist, hist_n;
  logic [FILL_W-1:0]    fill, fill_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic                 hit;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pat_r       <= PAT_RESET;
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      pat_r       <= pat_n;
      hist        <= hist_n;
      fill        <= fill_n;
      match_q     <= hit;
      match_count <= cnt_n;
    end
  end

  // Match evaluation, history shift and counter update
  always_comb begin
    pat_n  = pat_r;
    hist_n = hist;
    fill_n = fill;
    cnt_n  = match_count;
    hit    = data_valid & ~pattern_load & (fill == FILL_MAX) & ({hist, data_in} == pat_r);

    if (pattern_load) begin
      pat_n  = pattern;
      hist_n = '0;
      fill_n = '0;
    end else if (data_valid) begin
      hist_n = HIST_W'({hist, data_in});
      // Non-overlap: bits of a completed match may not seed the next one
      if (hit && !overlap) begin
        fill_n = '0;
      end else if (fill != FILL_MAX) begin
        fill_n = fill + FILL_W'(1);
      end
    end

    if (count_clear) begin
      cnt_n = '0;
    end else if (hit && (match_count != {CNT_WIDTH{1'b1}})) begin
      cnt_n = match_count + CNT_WIDTH'(1);
    end
  end

  assign match = hit;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default, 2-bit-counter and 8-bit-pattern instances.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       data_in, data_valid, pattern_load, overlap, count_clear;
  logic [3:0] pattern4;
  logic [7:0] pattern8;

  logic       match0, mq0;
  logic [7:0] cnt0;
  logic       match2, mq2;
  logic [1:0] cnt2;
  logic       match8, mq8;
  logic [7:0] cnt8;

  logic m0, m2, m8;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  seq_detect_param u0 (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .pattern(pattern4), .pattern_load(pattern_load), .overlap(overlap),
    .count_clear(count_clear), .match(match0), .match_q(mq0), .match_count(cnt0)
  );

  seq_detect_param #(.CNT_WIDTH(2)) u2 (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .pattern(pattern4), .pattern_load(pattern_load), .overlap(overlap),
    .count_clear(count_clear), .match(match2), .match_q(mq2), .match_count(cnt2)
  );

  seq_detect_param #(.PAT_WIDTH(8), .PAT_RESET(8'h00)) u8 (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .pattern(pattern8), .pattern_load(pattern_load), .overlap(overlap),
    .count_clear(count_clear), .match(match8), .match_q(mq8), .match_count(cnt8)
  );

  // One clock: drive at negedge, capture combinational matches, return just after posedge
  task automatic cyc(input logic d, input logic v, input logic ld, input logic clr);
    @(negedge clk);
    data_in      = d;
    data_valid   = v;
    pattern_load = ld;
    count_clear  = clr;
    #1;
    m0 = match0;
    m2 = match2;
    m8 = match8;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    data_in = 1'b0; data_valid = 1'b0; pattern_load = 1'b0; count_clear = 1'b0;
    overlap = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    data_in = 1'b1; data_valid = 1'b1; pattern_load = 1'b0; count_clear = 1'b0;
    overlap = 1'b1; pattern4 = 4'h0; pattern8 = 8'h00;
    #12;
    vecs++; if (match0 !== 1'b0) begin errs++; $display("FAIL reset_match got %b want 0", match0); end
    vecs++; if (mq0 !== 1'b0) begin errs++; $display("FAIL reset_match_q got %b want 0", mq0); end
    vecs++; if (cnt0 !== 8'd0) begin errs++; $display("FAIL reset_count got %0d want 0", cnt0); end
    vecs++; if (cnt8 !== 8'd0) begin errs++; $display("FAIL reset_count8 got %0d want 0", cnt8); end
    do_reset();
  endtask

  task automatic test_overlap_1101();
    logic [6:0] stim = 7'b1101101;
    logic [6:0] exp  = 7'b0001001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(stim[6-i], 1'b1, 1'b0, 1'b0);
      vecs++; if (m0 !== exp[6-i]) begin errs++; $display("FAIL ovl_match bit%0d got %b want %b", i+1, m0, exp[6-i]); end
      vecs++; if (mq0 !== exp[6-i]) begin errs++; $display("FAIL ovl_match_q bit%0d got %b want %b", i+1, mq0, exp[6-i]); end
    end
    vecs++; if (cnt0 !== 8'd2) begin errs++; $display("FAIL ovl_count got %0d want 2", cnt0); end
  endtask

  task automatic test_nonoverlap();
    logic [4:0] exp_no = 5'b00010;
    logic [4:0] exp_ov = 5'b00011;
    do_reset();
    pattern4 = 4'b1111;
    overlap  = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    vecs++; if (m0 !== 1'b0) begin errs++; $display("FAIL load_match got %b want 0", m0); end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      vecs++; if (m0 !== exp_no[4-i]) begin errs++; $display("FAIL nonovl_match bit%0d got %b want %b", i+1, m0, exp_no[4-i]); end
    end
    vecs++; if (cnt0 !== 8'd1) begin errs++; $display("FAIL nonovl_count got %0d want 1", cnt0); end
    overlap = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      vecs++; if (m0 !== exp_ov[4-i]) begin errs++; $display("FAIL ovl1111_match bit%0d got %b want %b", i+1, m0, exp_ov[4-i]); end
    end
    vecs++; if (cnt0 !== 8'd3) begin errs++; $display("FAIL ovl1111_count got %0d want 3", cnt0); end
  endtask

  task automatic test_gaps();
    logic [3:0] stim = 4'b1101;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(stim[3-k], 1'b1, 1'b0, 1'b0);
      vecs++; if (m0 !== (k == 3)) begin errs++; $display("FAIL gap_match bit%0d got %b want %b", k+1, m0, (k == 3)); end
      if (k < 3) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b1, 1'b0, 1'b0, 1'b0);
          vecs++; if (m0 !== 1'b0) begin errs++; $display("FAIL gap_idle bit%0d gap%0d got %b want 0", k+1, g, m0); end
        end
      end
    end
    vecs++; if (cnt0 !== 8'd1) begin errs++; $display("FAIL gap_count got %0d want 1", cnt0); end
  endtask

  task automatic test_width8();
    logic [2:0] pre  = 3'b101;
    logic [7:0] stim = 8'hA5;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(pre[2-i], 1'b1, 1'b0, 1'b0);
      vecs++; if (m8 !== 1'b0) begin errs++; $display("FAIL w8_prefix bit%0d got %b want 0", i+1, m8); end
    end
    pattern8 = 8'hA5;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    vecs++; if (m8 !== 1'b0) begin errs++; $display("FAIL w8_load got %b want 0", m8); end
    for (int i = 0; i < 8; i++) begin
      cyc(stim[7-i], 1'b1, 1'b0, 1'b0);
      vecs++; if (m8 !== (i == 7)) begin errs++; $display("FAIL w8_match bit%0d got %b want %b", i+1, m8, (i == 7)); end
    end
    vecs++; if (mq8 !== 1'b1) begin errs++; $display("FAIL w8_match_q got %b want 1", mq8); end
    vecs++; if (cnt8 !== 8'd1) begin errs++; $display("FAIL w8_count got %0d want 1", cnt8); end
  endtask

  task automatic test_saturate();
    logic [15:0] stim = 16'b1101101101101101;
    logic [15:0] exp  = 16'b0001001001001001;
    logic [1:0]  ecnt = 2'd0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(stim[15-i], 1'b1, 1'b0, 1'b0);
      if (exp[15-i] && ecnt != 2'd3) ecnt = ecnt + 2'd1;
      vecs++; if (m2 !== exp[15-i]) begin errs++; $display("FAIL sat_match bit%0d got %b want %b", i+1, m2, exp[15-i]); end
      vecs++; if (cnt2 !== ecnt) begin errs++; $display("FAIL sat_count bit%0d got %0d want %0d", i+1, cnt2, ecnt); end
    end
    vecs++; if (cnt0 !== 8'd5) begin errs++; $display("FAIL sat_wide_count got %0d want 5", cnt0); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    vecs++; if (m2 !== 1'b1) begin errs++; $display("FAIL clr_match got %b want 1", m2); end
    vecs++; if (cnt2 !== 2'd0) begin errs++; $display("FAIL clr_count got %0d want 0", cnt2); end
    vecs++; if (cnt0 !== 8'd0) begin errs++; $display("FAIL clr_wide_count got %0d want 0", cnt0); end
  endtask

  task automatic test_reset_midstream();
    logic [5:0] stim = 6'b110110;
    logic [2:0] tail = 3'b101;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(stim[5-i], 1'b1, 1'b0, 1'b0);
    vecs++; if (cnt0 !== 8'd1) begin errs++; $display("FAIL mid_precount got %0d want 1", cnt0); end
    // History now 110: a valid 1 would complete 1101 if reset did not discard it
    @(negedge clk);
    data_in = 1'b1; data_valid = 1'b1;
    n_rst = 1'b0;
    #1;
    vecs++; if (match0 !== 1'b0) begin errs++; $display("FAIL mid_match got %b want 0", match0); end
    vecs++; if (mq0 !== 1'b0) begin errs++; $display("FAIL mid_match_q got %b want 0", mq0); end
    vecs++; if (cnt0 !== 8'd0) begin errs++; $display("FAIL mid_count got %0d want 0", cnt0); end
    @(negedge clk);
    data_valid = 1'b0;
    n_rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    vecs++; if (m0 !== 1'b0) begin errs++; $display("FAIL post_rst_first got %b want 0", m0); end
    for (int i = 0; i < 3; i++) begin
      cyc(tail[2-i], 1'b1, 1'b0, 1'b0);
      vecs++; if (m0 !== (i == 2)) begin errs++; $display("FAIL post_rst_match bit%0d got %b want %b", i+2, m0, (i == 2)); end
    end
    vecs++; if (cnt0 !== 8'd1) begin errs++; $display("FAIL post_rst_count got %0d want 1", cnt0); end
  endtask

  initial begin
    test_reset();
    test_overlap_1101();
    test_nonoverlap();
    test_gaps();
    test_width8();
    test_saturate();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
